// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF and MEM port requests onto the MMU strobe bus.
// One access in flight; strobe held one full cycle, ack pulses the next.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic        mem_byte,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,
  output logic        stall,
  output logic        mmu_read,
  output logic        mmu_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wdata,
  output logic        mmu_byte,
  input  logic [31:0] mmu_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        last_mem_q, last_mem_d;
  logic        gnt_mem_q, gnt_mem_d;
  logic        mmu_read_q, mmu_read_d;
  logic        mmu_write_q, mmu_write_d;
  logic [31:0] mmu_addr_q, mmu_addr_d;
  logic [31:0] mmu_wdata_q, mmu_wdata_d;
  logic        mmu_byte_q, mmu_byte_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic        if_err_q, if_err_d;
  logic        mem_err_q, mem_err_d;

  logic        if_mis;
  logic        mem_mis;
  logic        pick_mem;

  assign if_mis   = if_addr[1:0] != 2'b00;
  assign mem_mis  = ~mem_byte & (mem_addr[1:0] != 2'b00);
  // Ties go to the port that did not win last time.
  assign pick_mem = mem_req & (~if_req | ~last_mem_q);

  // Next-state, grant and capture logic.
  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    gnt_mem_d   = gnt_mem_q;
    mmu_read_d  = 1'b0;
    mmu_write_d = 1'b0;
    mmu_addr_d  = mmu_addr_q;
    mmu_wdata_d = mmu_wdata_q;
    mmu_byte_d  = mmu_byte_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_err_d    = 1'b0;
    mem_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req | mem_req) begin
          last_mem_d = pick_mem;
          gnt_mem_d  = pick_mem;
          if (pick_mem) begin
            if (mem_mis) begin
              mem_err_d   = 1'b1;
              mem_ack_d   = 1'b1;
              mem_rdata_d = 32'h0;
              state_d     = DONE;
            end else begin
              mmu_addr_d  = mem_addr;
              mmu_wdata_d = mem_wdata;
              mmu_byte_d  = mem_byte;
              mmu_write_d = mem_we;
              mmu_read_d  = ~mem_we;
              state_d     = BUSY;
            end
          end else begin
            if (if_mis) begin
              if_err_d   = 1'b1;
              if_ack_d   = 1'b1;
              if_rdata_d = 32'h0;
              state_d    = DONE;
            end else begin
              mmu_addr_d = if_addr;
              mmu_byte_d = 1'b0;
              mmu_read_d = 1'b1;
              state_d    = BUSY;
            end
          end
        end
      end
      BUSY: begin
        if (gnt_mem_q) begin
          mem_rdata_d = mmu_write_q ? 32'h0 : mmu_rdata;
          mem_ack_d   = 1'b1;
        end else begin
          if_rdata_d = mmu_rdata;
          if_ack_d   = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, strobe and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      gnt_mem_q   <= 1'b0;
      mmu_read_q  <= 1'b0;
      mmu_write_q <= 1'b0;
      mmu_addr_q  <= 32'h0;
      mmu_wdata_q <= 32'h0;
      mmu_byte_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_err_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      gnt_mem_q   <= gnt_mem_d;
      mmu_read_q  <= mmu_read_d;
      mmu_write_q <= mmu_write_d;
      mmu_addr_q  <= mmu_addr_d;
      mmu_wdata_q <= mmu_wdata_d;
      mmu_byte_q  <= mmu_byte_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_err_q    <= if_err_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mmu_read  = mmu_read_q;
  assign mmu_write = mmu_write_q;
  assign mmu_addr  = mmu_addr_q;
  assign mmu_wdata = mmu_wdata_q;
  assign mmu_byte  = mmu_byte_q;
  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_err   = mem_err_q;
  assign stall     = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus randomized traffic against a
// transaction-level model of grant order, strobes and returned data.
`timescale 1ns/1ps
module tb_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        bm;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          cyc;
    logic        rd, wr, bm, ireq, mreq, stall;
    logic [31:0] addr, wdata;
    logic        ia, ie, ma, me;
    logic [31:0] ird, mrd;
  } samp_t;

  typedef struct {
    int          cyc;
    logic        rd, wr, bm, ireq;
    logic [31:0] addr, wdata;
  } stb_t;

  typedef struct {
    int          cyc;
    logic        mem;
    logic [31:0] rdata;
    logic        err;
    logic        stall;
  } ack_t;

  typedef struct {
    bit          mem, mis, rd, wr, bm, err;
    logic [31:0] addr, wdata, rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ack, if_err;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_byte = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_ack, mem_err, stall;
  logic        mmu_read, mmu_write, mmu_byte;
  logic [31:0] mmu_addr, mmu_wdata, mmu_rdata;
  logic [31:0] rd_key = 32'h0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  samp_t log_q[$];
  stb_t  stbs_q[$];
  ack_t  acks_q[$];
  exp_t  exp_q[$];
  int    n_both, n_consec, first_req;
  bit    model_last_mem = 1'b0;

  txn_t if_txns[$];
  txn_t mem_txns[$];
  int   if_idx = 0;
  int   mem_idx = 0;
  bit   if_seen, if_dropped, mem_seen;
  bit   if_drop_early = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .stall(stall),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_wdata(mmu_wdata), .mmu_byte(mmu_byte), .mmu_rdata(mmu_rdata)
  );

  always #5 clk = ~clk;

  // MMU model: read data is a keyed function of the address.
  assign mmu_rdata = mmu_addr ^ rd_key;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    log_q.push_back('{cyc, mmu_read, mmu_write, mmu_byte, if_req, mem_req,
                      stall, mmu_addr, mmu_wdata, if_ack, if_err, mem_ack,
                      mem_err, if_rdata, mem_rdata});

  // IF requester: holds req until ack, optionally drops it once granted.
  always begin
    @(negedge clk);
    if_seen = (if_ack === 1'b1);
    @(posedge clk);
    #1;
    if (if_seen) begin
      if_idx = if_idx + 1;
      if_dropped = 1'b0;
    end
    if (if_idx < if_txns.size() && !if_dropped) begin
      if_addr = if_txns[if_idx].addr;
      if_req  = 1'b1;
      if (if_drop_early && mmu_read === 1'b1 && mmu_addr === if_addr) begin
        if_req = 1'b0;
        if_dropped = 1'b1;
      end
    end else begin
      if_req = 1'b0;
    end
  end

  // MEM requester: presents queued transactions back to back.
  always begin
    @(negedge clk);
    mem_seen = (mem_ack === 1'b1);
    @(posedge clk);
    #1;
    if (mem_seen) mem_idx = mem_idx + 1;
    if (mem_idx < mem_txns.size()) begin
      mem_req   = 1'b1;
      mem_addr  = mem_txns[mem_idx].addr;
      mem_we    = mem_txns[mem_idx].we;
      mem_byte  = mem_txns[mem_idx].bm;
      mem_wdata = mem_txns[mem_idx].wdata;
    end else begin
      mem_req = 1'b0;
    end
  end

  function automatic exp_t make_exp(bit is_mem, txn_t t);
    exp_t e;
    e.mem   = is_mem;
    e.addr  = t.addr;
    e.wdata = t.wdata;
    e.bm    = is_mem ? t.bm : 1'b0;
    e.mis   = (t.addr[1:0] != 2'b00) && !(is_mem && t.bm);
    e.wr    = !e.mis && is_mem && t.we;
    e.rd    = !e.mis && !(is_mem && t.we);
    e.err   = e.mis;
    e.rdata = (e.mis || e.wr) ? 32'h0 : (t.addr ^ rd_key);
    return e;
  endfunction

  // Expected completion order: alternate while both pending, else lone port.
  task automatic plan(int i0, int m0);
    int  i = i0;
    int  m = m0;
    bit  pm;
    exp_q.delete();
    while (i < if_txns.size() || m < mem_txns.size()) begin
      pm = (m < mem_txns.size()) && (!(i < if_txns.size()) || !model_last_mem);
      if (pm) begin
        exp_q.push_back(make_exp(1'b1, mem_txns[m]));
        m++;
      end else begin
        exp_q.push_back(make_exp(1'b0, if_txns[i]));
        i++;
      end
      model_last_mem = pm;
    end
  endtask

  task automatic drain(output bit to);
    int n = 0;
    while ((if_idx < if_txns.size() || mem_idx < mem_txns.size()) && n < 300) begin
      @(negedge clk);
      n++;
    end
    to = (n >= 300);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic extract(int from);
    acks_q.delete();
    stbs_q.delete();
    n_both = 0;
    n_consec = 0;
    first_req = -1;
    for (int i = from; i < log_q.size(); i++) begin
      samp_t s;
      s = log_q[i];
      if (first_req < 0 && (s.ireq === 1'b1 || s.mreq === 1'b1)) first_req = s.cyc;
      if (s.rd === 1'b1 && s.wr === 1'b1) n_both++;
      if ((s.rd === 1'b1 || s.wr === 1'b1) && i > from &&
          (log_q[i-1].rd === 1'b1 || log_q[i-1].wr === 1'b1)) n_consec++;
      if (s.rd === 1'b1 || s.wr === 1'b1)
        stbs_q.push_back('{s.cyc, s.rd, s.wr, s.bm, s.ireq, s.addr, s.wdata});
      if (s.ma === 1'b1) acks_q.push_back('{s.cyc, 1'b1, s.mrd, s.me, s.stall});
      if (s.ia === 1'b1) acks_q.push_back('{s.cyc, 1'b0, s.ird, s.ie, s.stall});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mmu_read, mmu_write, mmu_byte} !== 3'b000)
      $display("FAIL rst_strobes: got %b want 000", {mmu_read, mmu_write, mmu_byte});
    else passes++;
    checks++;
    if ({mmu_addr, mmu_wdata, if_rdata, mem_rdata} !== 128'h0)
      $display("FAIL rst_regs: got %h %h %h %h want 0", mmu_addr, mmu_wdata, if_rdata, mem_rdata);
    else passes++;
    checks++;
    if ({if_ack, mem_ack, if_err, mem_err, stall} !== 5'b0)
      $display("FAIL rst_flags: got %b want 00000", {if_ack, mem_ack, if_err, mem_err, stall});
    else passes++;
    rst_n = 1'b1;
    model_last_mem = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int s;
    bit to;
    rd_key = 32'h8000_0004 ^ 32'h2402_0005;
    s = log_q.size();
    plan(if_txns.size(), mem_txns.size());
    if_txns.push_back('{addr: 32'h8000_0004, we: 1'b0, bm: 1'b0, wdata: 32'h0});
    model_last_mem = 1'b0;
    drain(to);
    extract(s);
    checks++;
    if (to) $display("FAIL fetch_done: timed out, want if_ack"); else passes++;
    checks++;
    if (stbs_q.size() != 1)
      $display("FAIL fetch_strobe_cnt: got %0d want 1", stbs_q.size());
    else passes++;
    if (stbs_q.size() == 1) begin
      checks++;
      if ({stbs_q[0].rd, stbs_q[0].wr, stbs_q[0].bm, stbs_q[0].addr} !== {3'b100, 32'h8000_0004} ||
          stbs_q[0].cyc != first_req + 1)
        $display("FAIL fetch_strobe: got rd%b wr%b b%b a=%h c=%0d want rd1 wr0 b0 a=80000004 c=%0d",
                 stbs_q[0].rd, stbs_q[0].wr, stbs_q[0].bm, stbs_q[0].addr, stbs_q[0].cyc, first_req + 1);
      else passes++;
    end
    checks++;
    if (acks_q.size() != 1 || acks_q[0].mem !== 1'b0 || acks_q[0].rdata !== 32'h2402_0005 ||
        acks_q[0].err !== 1'b0 || acks_q[0].cyc != first_req + 2)
      $display("FAIL fetch_ack: got n=%0d rdata=%h c=%0d want n=1 rdata=24020005 c=%0d",
               acks_q.size(), if_rdata, acks_q.size() > 0 ? acks_q[0].cyc : -1, first_req + 2);
    else passes++;
    checks++;
    if (acks_q.size() != 1 || acks_q[0].stall !== 1'b0)
      $display("FAIL fetch_stall: got stall=%b in ack cycle want 0", stall);
    else passes++;
    checks++;
    if (log_q[log_q.size()-1].ird !== 32'h2402_0005)
      $display("FAIL fetch_hold: got %h want 24020005", log_q[log_q.size()-1].ird);
    else passes++;
  endtask

  task automatic test_byte_write();
    int s;
    bit to;
    s = log_q.size();
    mem_txns.push_back('{addr: 32'h8040_0003, we: 1'b1, bm: 1'b1, wdata: 32'h0000_00A5});
    model_last_mem = 1'b1;
    drain(to);
    extract(s);
    checks++;
    if (to) $display("FAIL bw_done: timed out, want mem_ack"); else passes++;
    checks++;
    if (stbs_q.size() != 1 || {stbs_q[0].rd, stbs_q[0].wr, stbs_q[0].bm} !== 3'b011 ||
        stbs_q[0].addr !== 32'h8040_0003 || stbs_q[0].wdata !== 32'h0000_00A5)
      $display("FAIL bw_strobe: got n=%0d rd%b wr%b b%b wd=%h want n=1 rd0 wr1 b1 wd=000000a5",
               stbs_q.size(), mmu_read, mmu_write, mmu_byte, mmu_wdata);
    else passes++;
    checks++;
    if (acks_q.size() != 1 || acks_q[0].mem !== 1'b1 || acks_q[0].err !== 1'b0 ||
        acks_q[0].rdata !== 32'h0)
      $display("FAIL bw_ack: got n=%0d want one mem_ack err0 rdata0", acks_q.size());
    else passes++;
  endtask

  task automatic test_misaligned();
    int s;
    bit to;
    rd_key = $urandom();
    s = log_q.size();
    mem_txns.push_back('{addr: 32'h8000_0002, we: 1'b0, bm: 1'b0, wdata: 32'h0});
    model_last_mem = 1'b1;
    drain(to);
    extract(s);
    checks++;
    if (to) $display("FAIL mis_done: timed out, want mem_ack"); else passes++;
    checks++;
    if (stbs_q.size() != 0)
      $display("FAIL mis_strobe: got %0d strobe cycles want 0", stbs_q.size());
    else passes++;
    checks++;
    if (acks_q.size() != 1 || acks_q[0].mem !== 1'b1 || acks_q[0].err !== 1'b1 ||
        acks_q[0].rdata !== 32'h0 || acks_q[0].cyc != first_req + 1)
      $display("FAIL mis_ack: got n=%0d err=%b rdata=%h want n=1 err=1 rdata=0 one cycle after grant",
               acks_q.size(), acks_q.size() > 0 ? acks_q[0].err : 1'bx, mem_rdata);
    else passes++;
  endtask

  task automatic test_early_drop();
    int s;
    bit to;
    logic [31:0] a;
    a = $urandom() & 32'hFFFF_FFFC;
    rd_key = $urandom();
    if_drop_early = 1'b1;
    s = log_q.size();
    if_txns.push_back('{addr: a, we: 1'b0, bm: 1'b0, wdata: 32'h0});
    model_last_mem = 1'b0;
    drain(to);
    extract(s);
    if_drop_early = 1'b0;
    checks++;
    if (to) $display("FAIL drop_done: timed out, want if_ack"); else passes++;
    checks++;
    if (stbs_q.size() != 1 || stbs_q[0].ireq !== 1'b0 || stbs_q[0].rd !== 1'b1)
      $display("FAIL drop_strobe: got n=%0d want one read with if_req low", stbs_q.size());
    else passes++;
    checks++;
    if (acks_q.size() != 1 || acks_q[0].mem !== 1'b0 || acks_q[0].rdata !== (a ^ rd_key))
      $display("FAIL drop_ack: got n=%0d rdata=%h want n=1 rdata=%h", acks_q.size(), if_rdata, a ^ rd_key);
    else passes++;
  endtask

  task automatic test_contention();
    int s, lo, last;
    bit to;
    rd_key = $urandom();
    s = log_q.size();
    plan(if_txns.size(), mem_txns.size());
    for (int k = 0; k < 2; k++) begin
      if_txns.push_back('{addr: $urandom() & 32'hFFFF_FFFC, we: 1'b0, bm: 1'b0, wdata: 32'h0});
      mem_txns.push_back('{addr: $urandom() & 32'hFFFF_FFFC, we: 1'($urandom_range(1)),
                           bm: 1'($urandom_range(1)), wdata: $urandom()});
    end
    plan(if_txns.size() - 2, mem_txns.size() - 2);
    drain(to);
    extract(s);
    checks++;
    if (to) $display("FAIL cont_done: timed out"); else passes++;
    checks++;
    if (acks_q.size() != 4) $display("FAIL cont_cnt: got %0d acks want 4", acks_q.size());
    else passes++;
    if (acks_q.size() == 4) begin
      checks++;
      if ({acks_q[0].mem, acks_q[1].mem, acks_q[2].mem, acks_q[3].mem} !== 4'b1010)
        $display("FAIL cont_order: got %b%b%b%b want 1010 (1=MEM)",
                 acks_q[0].mem, acks_q[1].mem, acks_q[2].mem, acks_q[3].mem);
      else passes++;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (acks_q[k].rdata !== exp_q[k].rdata)
          $display("FAIL cont_rdata[%0d]: got %h want %h", k, acks_q[k].rdata, exp_q[k].rdata);
        else passes++;
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (acks_q[k].cyc - acks_q[k-1].cyc != 3)
          $display("FAIL cont_gap[%0d]: got %0d want 3", k, acks_q[k].cyc - acks_q[k-1].cyc);
        else passes++;
      end
      last = acks_q[3].cyc;
      lo = 0;
      for (int i = s; i < log_q.size(); i++)
        if (log_q[i].cyc >= first_req && log_q[i].cyc < last && log_q[i].stall !== 1'b1) lo++;
      checks++;
      if (lo != 0 || acks_q[3].stall !== 1'b0)
        $display("FAIL cont_stall: got %0d low cycles, final=%b want 0 low, final=0", lo, acks_q[3].stall);
      else passes++;
    end
  endtask

  task automatic test_reset_busy();
    int s, n;
    bit to;
    logic [31:0] a;
    a = $urandom() & 32'hFFFF_FFFC;
    rd_key = $urandom();
    mem_txns.push_back('{addr: a, we: 1'b0, bm: 1'b0, wdata: 32'h0});
    n = 0;
    while (mmu_read !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) $display("FAIL rb_strobe: no mmu_read seen, want one"); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mmu_read, mmu_write, mmu_byte, mmu_addr, mmu_wdata, mem_rdata, if_rdata,
         mem_ack, if_ack, mem_err, if_err} !== '0)
      $display("FAIL rb_clear: got rd=%b a=%h mrd=%h want all 0", mmu_read, mmu_addr, mem_rdata);
    else passes++;
    model_last_mem = 1'b0;
    s = log_q.size();
    repeat (3) @(negedge clk);
    #1;
    extract(s);
    checks++;
    if (acks_q.size() != 0 || stbs_q.size() != 0)
      $display("FAIL rb_quiet: got %0d acks %0d strobes in reset want 0", acks_q.size(), stbs_q.size());
    else passes++;
    rst_n = 1'b1;
    s = log_q.size();
    model_last_mem = 1'b1;
    drain(to);
    extract(s);
    checks++;
    if (to || acks_q.size() != 1 || acks_q[0].mem !== 1'b1 || acks_q[0].rdata !== (a ^ rd_key) ||
        stbs_q.size() != 1)
      $display("FAIL rb_regrant: got to=%b acks=%0d strobes=%0d rdata=%h want 1 ack rdata=%h",
               to, acks_q.size(), stbs_q.size(), mem_rdata, a ^ rd_key);
    else passes++;
  endtask

  task automatic test_random();
    int s, na, ni, nm;
    bit to, found;
    ack_t ak;
    stb_t st;
    txn_t t;
    for (int r = 0; r < 10; r++) begin
      rd_key = $urandom();
      ni = $urandom_range(3);
      nm = $urandom_range(3);
      if (ni + nm == 0) nm = 1;
      s = log_q.size();
      for (int k = 0; k < ni; k++) begin
        t.addr  = $urandom();
        if ($urandom_range(1) == 1) t.addr[1:0] = 2'b00;
        t.we = 1'b0; t.bm = 1'b0; t.wdata = 32'h0;
        if_txns.push_back(t);
      end
      for (int k = 0; k < nm; k++) begin
        t.addr  = $urandom();
        if ($urandom_range(1) == 1) t.addr[1:0] = 2'b00;
        t.we    = 1'($urandom_range(1));
        t.bm    = 1'($urandom_range(1));
        t.wdata = $urandom();
        mem_txns.push_back(t);
      end
      plan(if_txns.size() - ni, mem_txns.size() - nm);
      drain(to);
      extract(s);
      checks++;
      if (to || acks_q.size() != exp_q.size())
        $display("FAIL rnd%0d_cnt: got to=%b acks=%0d want %0d", r, to, acks_q.size(), exp_q.size());
      else passes++;
      checks++;
      if (n_both != 0 || n_consec != 0)
        $display("FAIL rnd%0d_strobe_rule: got both=%0d consec=%0d want 0 0", r, n_both, n_consec);
      else passes++;
      na = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
        ak.cyc = -1;
        if (k < acks_q.size()) ak = acks_q[k];
        checks++;
        if (ak.cyc < 0 || ak.mem !== exp_q[k].mem || ak.rdata !== exp_q[k].rdata ||
            ak.err !== exp_q[k].err)
          $display("FAIL rnd%0d_ack[%0d]: got mem=%b rd=%h err=%b want mem=%b rd=%h err=%b",
                   r, k, ak.mem, ak.rdata, ak.err, exp_q[k].mem, exp_q[k].rdata, exp_q[k].err);
        else passes++;
        found = 1'b0;
        for (int j = 0; j < stbs_q.size(); j++)
          if (stbs_q[j].cyc == ak.cyc - 1) begin
            found = 1'b1;
            st = stbs_q[j];
          end
        if (!exp_q[k].mis) na++;
        checks++;
        if (exp_q[k].mis ? found :
            (!found || st.rd !== exp_q[k].rd || st.wr !== exp_q[k].wr || st.bm !== exp_q[k].bm ||
             st.addr !== exp_q[k].addr || (exp_q[k].wr && st.wdata !== exp_q[k].wdata)))
          $display("FAIL rnd%0d_strobe[%0d]: got found=%b rd%b wr%b a=%h want mis=%b rd%b wr%b a=%h",
                   r, k, found, st.rd, st.wr, st.addr, exp_q[k].mis, exp_q[k].rd, exp_q[k].wr,
                   exp_q[k].addr);
        else passes++;
      end
      checks++;
      if (stbs_q.size() != na)
        $display("FAIL rnd%0d_strobe_cnt: got %0d want %0d", r, stbs_q.size(), na);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_byte_write();
    test_misaligned();
    test_early_drop();
    test_contention();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
